// File: rtl/match_ctrl.sv
// Best-of-N tug-of-war match sequencer: random arm delay, go window, false-start and timeout replay.
// Press-to-point latency 1 cycle; no backpressure, presses outside ARM/GO are dropped.
module match_ctrl #(
    parameter int WIN_ROUNDS   = 3,
    parameter int SCORE_W      = 3,
    parameter int DELAY_MIN    = 2,
    parameter int DELAY_RAND_W = 3,
    parameter int TIMEOUT      = 32,
    parameter int TIMEOUT_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slowenable,
    input  logic               start,
    input  logic               press_l,
    input  logic               press_r,
    output logic               leds_on,
    output logic               clear,
    output logic               pt_l,
    output logic               pt_r,
    output logic               false_start,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               match_l,
    output logic               match_r,
    output logic               busy
);
    localparam int DLY_W = $clog2(DELAY_MIN + (1 << DELAY_RAND_W));

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ARM, S_GO, S_POINT, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [7:0]           lfsr;
    logic [DLY_W-1:0]     dly_cnt;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 new_match, award_l, award_r, early;
    logic                 enter_go, tick_arm, tick_go, win_l, win_r;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        new_match = 1'b0;
        award_l   = 1'b0;
        award_r   = 1'b0;
        early     = 1'b0;
        enter_go  = 1'b0;
        tick_arm  = 1'b0;
        tick_go   = 1'b0;
        win_l     = 1'b0;
        win_r     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                    new_match = 1'b1;
                end
            end
            S_CLEAR: state_nxt = S_ARM;
            S_ARM: begin
                // presses outrank the delay expiring on the same cycle
                if (press_l && press_r) begin
                    state_nxt = S_CLEAR;
                end else if (press_l) begin
                    award_r   = 1'b1;
                    early     = 1'b1;
                    state_nxt = S_POINT;
                end else if (press_r) begin
                    award_l   = 1'b1;
                    early     = 1'b1;
                    state_nxt = S_POINT;
                end else if (slowenable) begin
                    tick_arm = 1'b1;
                    if (dly_cnt == DLY_W'(1)) begin
                        enter_go  = 1'b1;
                        state_nxt = S_GO;
                    end
                end
            end
            S_GO: begin
                if (press_l && press_r) begin
                    state_nxt = S_CLEAR;
                end else if (press_l) begin
                    award_l   = 1'b1;
                    state_nxt = S_POINT;
                end else if (press_r) begin
                    award_r   = 1'b1;
                    state_nxt = S_POINT;
                end else if (slowenable) begin
                    tick_go = 1'b1;
                    if (to_cnt == TIMEOUT_W'(1)) state_nxt = S_CLEAR;
                end
            end
            S_POINT: begin
                if (pt_l && score_l == SCORE_W'(WIN_ROUNDS)) begin
                    win_l     = 1'b1;
                    state_nxt = S_DONE;
                end else if (pt_r && score_r == SCORE_W'(WIN_ROUNDS)) begin
                    win_r     = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_CLEAR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr        <= 8'hA5;
            dly_cnt     <= '0;
            to_cnt      <= '0;
            pt_l        <= 1'b0;
            pt_r        <= 1'b0;
            false_start <= 1'b0;
            score_l     <= '0;
            score_r     <= '0;
            match_l     <= 1'b0;
            match_r     <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            pt_l <= award_l;
            pt_r <= award_r;
            if (new_match) begin
                score_l <= '0;
                score_r <= '0;
                match_l <= 1'b0;
                match_r <= 1'b0;
            end else begin
                if (award_l && score_l < SCORE_W'(WIN_ROUNDS)) score_l <= score_l + SCORE_W'(1);
                if (award_r && score_r < SCORE_W'(WIN_ROUNDS)) score_r <= score_r + SCORE_W'(1);
                if (win_l) match_l <= 1'b1;
                if (win_r) match_r <= 1'b1;
            end
            // cleared on entry so the flag already reads low during CLEAR
            if (state_nxt == S_CLEAR) false_start <= 1'b0;
            else if (early)           false_start <= 1'b1;
            if (state == S_CLEAR)
                dly_cnt <= DLY_W'(DELAY_MIN) + DLY_W'(lfsr[DELAY_RAND_W-1:0]);
            else if (tick_arm)
                dly_cnt <= dly_cnt - DLY_W'(1);
            if (enter_go)     to_cnt <= TIMEOUT_W'(TIMEOUT);
            else if (tick_go) to_cnt <= to_cnt - TIMEOUT_W'(1);
        end
    end

    assign leds_on = (state == S_GO);
    assign clear   = (state == S_CLEAR);
    assign busy    = !(state == S_IDLE || state == S_DONE);

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboarded bench for match_ctrl: point events queued at press time, arm delay predicted from the LFSR.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_match_ctrl;
    localparam int SCORE_W      = 3;
    localparam int DELAY_MIN    = 2;
    localparam int DELAY_RAND_W = 3;
    localparam int EW           = 3 + 2 * SCORE_W;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               slowenable = 1'b0;
    logic               start = 1'b0;
    logic               press_l = 1'b0;
    logic               press_r = 1'b0;
    logic               leds_on, clear, pt_l, pt_r, false_start;
    logic [SCORE_W-1:0] score_l, score_r;
    logic               match_l, match_r, busy;

    match_ctrl #(
        .WIN_ROUNDS(3), .SCORE_W(SCORE_W), .DELAY_MIN(DELAY_MIN),
        .DELAY_RAND_W(DELAY_RAND_W), .TIMEOUT(4), .TIMEOUT_W(6)
    ) dut (
        .clk(clk), .rst(rst), .slowenable(slowenable), .start(start),
        .press_l(press_l), .press_r(press_r), .leds_on(leds_on), .clear(clear),
        .pt_l(pt_l), .pt_r(pt_r), .false_start(false_start),
        .score_l(score_l), .score_r(score_r), .match_l(match_l), .match_r(match_r),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int                 n_chk = 0;
    int                 n_err = 0;
    logic [EW-1:0]      pt_q[$];
    logic [SCORE_W-1:0] exp_l = '0;
    logic [SCORE_W-1:0] exp_r = '0;
    logic [7:0]         m_lfsr = 8'hA5;
    int                 arm_ticks = 0;
    int                 exp_delay = 0;
    bit                 delay_vld = 1'b0;
    bit                 prev_arm = 1'b0;
    bit                 prev_leds = 1'b0;
    logic               last_se = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs once per rising edge; inputs still hold the values that edge sampled.
    task automatic observe();
        logic [EW-1:0] exp_pt;
        if (!rst) m_lfsr = 8'hA5;
        else      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (prev_arm && slowenable) arm_ticks++;
        if (clear) begin
            exp_delay = DELAY_MIN + int'(m_lfsr[DELAY_RAND_W-1:0]);
            arm_ticks = 0;
            delay_vld = 1'b1;
        end
        if (leds_on && !prev_leds && delay_vld) begin
            chk("arm_delay", arm_ticks, exp_delay);
            delay_vld = 1'b0;
        end
        if (pt_l || pt_r) begin
            if (pt_q.size() == 0) begin
                chk("unexpected_point", {pt_l, pt_r}, 0);
            end else begin
                exp_pt = pt_q.pop_front();
                chk("point", {pt_l, pt_r, false_start, score_l, score_r}, exp_pt);
            end
        end
        prev_arm  = busy && !clear && !leds_on && !pt_l && !pt_r;
        prev_leds = leds_on;
    endtask

    task automatic step(input logic se, input logic pl, input logic pr, input logic st);
        @(negedge clk);
        observe();
        slowenable = se;
        press_l    = pl;
        press_r    = pr;
        start      = st;
        last_se    = se;
    endtask

    task automatic push_pt(input logic l, input logic r, input logic fs);
        if (l) exp_l = exp_l + 1'b1;
        if (r) exp_r = exp_r + 1'b1;
        pt_q.push_back({l, r, fs, exp_l, exp_r});
    endtask

    task automatic wait_go();
        for (int i = 0; i < 200; i++) begin
            step(i % 2 == 0, 1'b0, 1'b0, 1'b0);
            if (leds_on) return;
        end
        chk("wait_go_timeout", 0, 1);
    endtask

    // Leaves GO having seen exactly three ticks, counting one possibly given by wait_go.
    task automatic go_three_ticks();
        int n = int'(last_se);
        while (n < 3) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_in_arm(input string tag);
        chk(tag, {busy, clear, leds_on}, 3'b100);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_outputs", {leds_on, clear, pt_l, pt_r, false_start, score_l, score_r,
                              match_l, match_r, busy}, 0);
        rst = 1'b1;

        // full match won by L
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_clear", clear, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_in_arm("start_arm");
        for (int r = 1; r <= 3; r++) begin
            wait_go();
            step(1'b0, 1'b1, 1'b0, 1'b0);
            push_pt(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (r < 3) chk("round_clear", clear, 1);
            else       chk("match_l", match_l, 1);
        end
        chk("done_state", {match_r, busy, score_l, score_r}, {2'b00, 3'd3, 3'd0});

        // start from DONE
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp_l = '0;
        exp_r = '0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart", {clear, match_l, score_l, score_r}, {2'b10, 3'd0, 3'd0});

        // false start by R
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_in_arm("fs_arm");
        step(1'b0, 1'b0, 1'b1, 1'b0);
        push_pt(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fs_cleared", {clear, false_start}, 2'b10);

        // start while busy
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_in_arm("busy_start_ignored");
        chk("busy_start_score", {score_l, score_r}, {exp_l, exp_r});

        // simultaneous press in GO
        wait_go();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("both_clear", clear, 1);
        chk("both_score", {score_l, score_r}, {exp_l, exp_r});
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_in_arm("both_rearm");

        // timeout replay
        wait_go();
        go_three_ticks();
        chk("pre_timeout_go", leds_on, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("timeout_clear", {clear, leds_on}, 2'b10);

        // press on the final tick wins the point
        wait_go();
        go_three_ticks();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        push_pt(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("last_tick_clear", clear, 1);

        // reset while in GO
        wait_go();
        chk("pre_reset_go", leds_on, 1);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("reset_mid_go", {leds_on, clear, pt_l, pt_r, false_start, score_l, score_r,
                             match_l, match_r, busy}, 0);
        exp_l = '0;
        exp_r = '0;

        // fresh match after reset uses the reset LFSR sequence
        step(1'b0, 1'b0, 1'b0, 1'b1);
        wait_go();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        push_pt(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        chk("queue_drained", pt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/match_ctrl.md
# match_ctrl

Parametrised best-of-N master controller for the tug-of-war game. It sequences whole matches rather than single rounds: it arms a pseudo-random start delay, lights the "go" LEDs, arbitrates the first press, detects false starts, keeps per-player scores and declares the match winner. It sits between the debounced button/slow-tick logic and the LED/score display path.

## Interface
- WIN_ROUNDS, 3: points needed to win the match; must be less than 2^SCORE_W.
- SCORE_W, 3: width of the score outputs.
- DELAY_MIN, 2: minimum arm delay, in slowenable ticks.
- DELAY_RAND_W, 3: random delay span; delay = DELAY_MIN + 0..2^DELAY_RAND_W-1 ticks.
- TIMEOUT, 32: slowenable ticks in GO without a press before the round is replayed; must be at least 1.
- TIMEOUT_W, 6: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset; synchronous and active-low. rst=0 at a rising clk edge resets the block.
- slowenable  in  1  one-cycle tick that paces all delays and timeouts.
- start  in  1  one-cycle request for a new match; honoured only in IDLE or DONE.
- press_l, press_r  in  1  debounced one-cycle button pulses.
- leds_on  out  1  go indicator; high only in GO.
- clear  out  1  high for the single cycle the FSM is in CLEAR.
- pt_l, pt_r  out  1  one-cycle point pulse, high during POINT for the player who scored.
- false_start  out  1  set when a point is awarded for an early press; cleared in CLEAR.
- score_l, score_r  out  SCORE_W  current scores.
- match_l, match_r  out  1  match-winner levels; held until the next start.
- busy  out  1  low in IDLE and DONE, high in all other states.

## Operation
- All outputs are Moore outputs decoded from registered state or taken from registers.
- Reset values: state IDLE; every output 0; LFSR 8'hA5; all counters 0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every clk cycle, including in IDLE.
- States:
  - IDLE: start goes to CLEAR. In the same edge, scores, match_l/match_r and false_start are zeroed.
  - CLEAR: one cycle. Loads delay counter = DELAY_MIN + LFSR[DELAY_RAND_W-1:0], then goes to ARM. Clears false_start.
  - ARM: the delay counter decrements on each slowenable. On slowenable with counter==1, go to GO and load the timeout counter with TIMEOUT.
    - press_l only: false start by L. Point to R, false_start set, go to POINT.
    - press_r only: false start by R. Point to L, false_start set, go to POINT.
    - Both presses in the same cycle: no point, go to CLEAR (replay).
    - A press takes priority over the delay expiring in the same cycle.
  - GO: the timeout counter decrements on slowenable.
    - press_l only: point to L, go to POINT.
    - press_r only: point to R, go to POINT.
    - Both presses: replay, go to CLEAR.
    - On slowenable with counter==1 and no press: replay, go to CLEAR.
    - A press beats a simultaneous final timeout tick.
  - POINT: one cycle; pt_x high.
    - If score_x==WIN_ROUNDS, go to DONE.
    - Otherwise go to CLEAR.
  - DONE: match_x=1 for the player who reached WIN_ROUNDS. start goes to CLEAR with the same zeroing as from IDLE.
- Scores:
  - The score increments on the edge that leaves ARM/GO for POINT, so it is already updated during POINT.
  - Scores never exceed WIN_ROUNDS and never wrap.
- start is ignored while busy=1.
- Presses in CLEAR, POINT, IDLE and DONE are ignored.

## Timing
- Press-to-point latency: a press sampled in cycle t gives pt_x and the new score in cycle t+1. clear follows at t+2, or match_x at t+2 on the final point.
- start in cycle t: clear is high in t+1, and ARM begins at t+2.
- Arm duration: exactly D slowenable ticks, D = DELAY_MIN + sampled LFSR bits. leds_on rises the cycle after the D-th tick.
- Timeout: exactly TIMEOUT ticks in GO. clear is high the cycle after the TIMEOUT-th tick.
- slowenable in CLEAR or POINT is not counted.
- rst=0 in any state returns to the reset values at that edge, including mid-round and in DONE.

## Test plan
- Reset mid-GO: rst=0 for 1 cycle while leds_on=1 -> next cycle all outputs 0, busy=0, score_l=score_r=0.
- Normal match, defaults: start, then press_l one cycle after leds_on rises, three rounds in a row -> pt_l pulses 3 times, score_l 1,2,3, match_l=1, match_r=0, busy=0, score_r=0.
- False start: press_r during ARM -> next cycle pt_l=1, score_l=1, false_start=1. The following CLEAR cycle -> false_start=0.
- Simultaneous press: press_l and press_r in the same GO cycle -> no pt pulse, scores unchanged, clear=1 the next cycle, new ARM.
- Timeout with TIMEOUT=4: no press for 4 ticks in GO -> replay via clear. A press on the 4th tick itself -> point awarded, no replay.
- Start ignored while busy: start pulse during ARM -> scores and state unchanged. start in DONE -> scores zeroed, match_l=0, clear=1 the next cycle.
